// File: rtl/adder_tree_pkg.sv
// rtl/adder_tree_pkg.sv - shared constants, state type and width helper for the adder tree feeder
package adder_tree_pkg;

  localparam int ADDER_WIDTH_DFLT = 64;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } feeder_state_t;

  // Width that holds the sum of `lanes` unsigned operands of `w` bits without overflow
  function automatic int sum_width(input int w, input int lanes);
    return w + $clog2(lanes);
  endfunction

endpackage

// File: rtl/adder_tree_lane_bank.sv
// rtl/adder_tree_lane_bank.sv - LANES x W operand register file with flattened read bus
module adder_tree_lane_bank
  import adder_tree_pkg::*;
#(
  parameter int W     = ADDER_WIDTH_DFLT,
  parameter int LANES = 8,
  localparam int IW   = $clog2(LANES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_we,
  input  logic [IW-1:0]      i_idx,
  input  logic [W-1:0]       i_data,
  output logic [LANES*W-1:0] o_bus
);

  logic [W-1:0] r_lanes [LANES];

  // Write one lane per accepted operand; lanes keep their value otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LANES; k++) begin
        r_lanes[k] <= '0;
      end
    end else if (i_we) begin
      r_lanes[i_idx] <= i_data;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_bus
    assign o_bus[g*W +: W] = r_lanes[g];
  end

endmodule

// File: rtl/adder_tree_feeder.sv
// rtl/adder_tree_feeder.sv - collects operands for the adder tree, captures and self-checks its sum
module adder_tree_feeder
  import adder_tree_pkg::*;
#(
  parameter int ADDER_WIDTH  = ADDER_WIDTH_DFLT,
  parameter int LANES        = 8,
  parameter int TREE_LATENCY = 2,
  localparam int SUM_WIDTH   = sum_width(ADDER_WIDTH, LANES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDER_WIDTH-1:0]       in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [LANES*ADDER_WIDTH-1:0] tree_operands,
  input  logic [SUM_WIDTH-1:0]         tree_sum,
  output logic [SUM_WIDTH-1:0]         out_sum,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_mismatch
);

  localparam int IW = $clog2(LANES);
  localparam int CW = $clog2(TREE_LATENCY + 1);

  feeder_state_t        r_state;
  logic [IW-1:0]        r_idx;
  logic [CW-1:0]        r_wait_cnt;
  logic [SUM_WIDTH-1:0] r_ref_acc;
  logic [SUM_WIDTH-1:0] r_out_sum;
  logic                 r_out_valid;
  logic                 r_out_mismatch;

  logic                 w_in_ready;
  logic                 w_accept;
  logic [SUM_WIDTH-1:0] w_in_ext;

  assign w_in_ready = (r_state == FILL);
  assign w_accept   = in_valid && w_in_ready;
  assign w_in_ext   = {{(SUM_WIDTH-ADDER_WIDTH){1'b0}}, in_data};

  assign in_ready     = w_in_ready;
  assign out_sum      = r_out_sum;
  assign out_valid    = r_out_valid;
  assign out_mismatch = r_out_mismatch;

  adder_tree_lane_bank #(
    .W     (ADDER_WIDTH),
    .LANES (LANES)
  ) u_lane_bank (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_accept),
    .i_idx  (r_idx),
    .i_data (in_data),
    .o_bus  (tree_operands)
  );

  // Fill lanes, wait out the tree latency, then hold the captured result until it is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= FILL;
      r_idx          <= '0;
      r_wait_cnt     <= '0;
      r_ref_acc      <= '0;
      r_out_sum      <= '0;
      r_out_valid    <= 1'b0;
      r_out_mismatch <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_ref_acc <= r_ref_acc + w_in_ext;
            r_idx     <= r_idx + IW'(1);
            if (r_idx == IW'(LANES - 1)) begin
              r_state    <= WAIT;
              r_wait_cnt <= CW'(TREE_LATENCY);
            end
          end
        end
        WAIT: begin
          if (r_wait_cnt == '0) begin
            r_out_sum      <= tree_sum;
            r_out_mismatch <= (tree_sum != r_ref_acc);
            r_out_valid    <= 1'b1;
            r_state        <= HOLD;
          end else begin
            r_wait_cnt <= r_wait_cnt - CW'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_idx       <= '0;
            r_ref_acc   <= '0;
            r_state     <= FILL;
          end
        end
        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_tree_feeder.sv
// tb/tb_adder_tree_feeder.sv - scoreboard bench for adder_tree_feeder with a pipelined tree model
module tb_adder_tree_feeder;

  localparam int W  = 64;
  localparam int L  = 8;
  localparam int TL = 2;
  localparam int SW = 67;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [W-1:0]    in_data;
  logic            in_valid;
  logic            in_ready;
  logic [L*W-1:0]  tree_operands;
  logic [SW-1:0]   tree_sum;
  logic [SW-1:0]   out_sum;
  logic            out_valid;
  logic            out_ready;
  logic            out_mismatch;

  adder_tree_feeder #(
    .ADDER_WIDTH  (W),
    .LANES        (L),
    .TREE_LATENCY (TL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .tree_operands (tree_operands),
    .tree_sum      (tree_sum),
    .out_sum       (out_sum),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_mismatch  (out_mismatch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Tree model: sum of the bus plus an injectable error, delayed TL edges
  logic [SW-1:0] bias;
  logic [SW-1:0] w_true_sum;
  logic [SW-1:0] tree_pipe [TL];

  always_comb begin
    w_true_sum = '0;
    for (int k = 0; k < L; k++) w_true_sum = w_true_sum + SW'(tree_operands[k*W +: W]);
  end

  always_ff @(posedge clk) begin
    tree_pipe[0] <= w_true_sum + bias;
    for (int s = 1; s < TL; s++) tree_pipe[s] <= tree_pipe[s-1];
  end

  assign tree_sum = tree_pipe[TL-1];

  typedef struct packed {
    logic [SW-1:0] sum;
    logic          mm;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic feed(input logic [W-1:0] ops [L], input bit gaps, output bit ok, output int last_cyc);
    int            k = 0;
    int            budget = 0;
    bit            acc;
    logic [SW-1:0] s = '0;
    exp_t          e;
    for (int i = 0; i < L; i++) s = s + SW'(ops[i]);
    e.sum = s + bias;
    e.mm  = (bias != '0);
    sb.push_back(e);
    last_cyc = 0;
    @(posedge clk); #1;
    while (k < L && budget < 300) begin
      in_data  = ops[k];
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      budget++;
      if (acc) begin
        k++;
        last_cyc = cyc;
      end
    end
    in_valid = 1'b0;
    ok = (k == L);
  endtask

  task automatic wait_valid(output bit found, output int at_cyc);
    found  = 0;
    at_cyc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) begin
        found  = 1;
        at_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({in_ready, out_valid, out_mismatch} !== 3'b100)
      $display("FAIL reset_flags: got %b want 100", {in_ready, out_valid, out_mismatch});
    else n_pass++;
    n_total++;
    if (out_sum !== '0) $display("FAIL reset_out_sum: got %0h want 0", out_sum);
    else n_pass++;
    n_total++;
    if (tree_operands !== '0) $display("FAIL reset_operands: got %0h want 0", tree_operands);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [W-1:0] ops [L];
    bit ok, found;
    int last, at;
    exp_t e;
    for (int i = 0; i < L; i++) ops[i] = W'(i + 1);
    out_ready = 1'b1;
    feed(ops, 0, ok, last);
    n_total++;
    if (!ok) $display("FAIL basic_feed: operands not all accepted");
    else n_pass++;
    wait_valid(found, at);
    n_total++;
    if (!found || (at - last) != TL + 1)
      $display("FAIL basic_latency: got found=%0d latency=%0d want %0d", found, at - last, TL + 1);
    else n_pass++;
    n_total++;
    if (sb.size() == 0) $display("FAIL basic_sum: scoreboard empty got %0h", out_sum);
    else begin
      e = sb.pop_front();
      if (out_sum !== e.sum || out_mismatch !== e.mm || out_sum !== SW'(36))
        $display("FAIL basic_sum: got %0d/%b want %0d/%b", out_sum, out_mismatch, e.sum, e.mm);
      else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL basic_rearm: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_max();
    logic [W-1:0] ops [L];
    bit ok, found;
    int last, at;
    exp_t e;
    for (int i = 0; i < L; i++) ops[i] = '1;
    out_ready = 1'b1;
    feed(ops, 0, ok, last);
    wait_valid(found, at);
    n_total++;
    if (!ok || !found || sb.size() == 0) $display("FAIL max_done: got ok=%0d found=%0d", ok, found);
    else begin
      e = sb.pop_front();
      if (out_sum !== e.sum || out_mismatch !== 1'b0 || out_sum !== 67'h7_FFFF_FFFF_FFFF_FFF8)
        $display("FAIL max_sum: got %0h/%b want %0h/0", out_sum, out_mismatch, e.sum);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ops [L];
    bit ok, found;
    int last, at, hs;
    logic [SW-1:0] snap_sum;
    logic snap_mm;
    exp_t e;
    for (int i = 0; i < L; i++) ops[i] = W'(3 * i + 5);
    out_ready = 1'b0;
    feed(ops, 0, ok, last);
    wait_valid(found, at);
    snap_sum = out_sum;
    snap_mm  = out_mismatch;
    n_total++;
    if (!found || sb.size() == 0) $display("FAIL bp_result: got found=%0d", found);
    else begin
      e = sb.pop_front();
      if (out_sum !== e.sum || out_mismatch !== e.mm)
        $display("FAIL bp_result: got %0d/%b want %0d/%b", out_sum, out_mismatch, e.sum, e.mm);
      else n_pass++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== snap_sum || out_mismatch !== snap_mm)
        $display("FAIL bp_stable: got v=%b r=%b s=%0d m=%b want 1/0/%0d/%b",
                 out_valid, in_ready, out_sum, out_mismatch, snap_sum, snap_mm);
      else n_pass++;
    end
    out_ready = 1'b1;
    hs = (out_valid && out_ready) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) hs++;
    end
    n_total++;
    if (hs != 1) $display("FAIL bp_handshakes: got %0d want 1", hs);
    else n_pass++;
  endtask

  task automatic test_mismatch();
    logic [W-1:0] ops [L];
    bit ok, found;
    int last, at;
    exp_t e;
    for (int i = 0; i < L; i++) ops[i] = W'(10 * (i + 1));
    out_ready = 1'b1;
    bias = SW'(1);
    feed(ops, 0, ok, last);
    wait_valid(found, at);
    n_total++;
    if (!ok || !found || sb.size() == 0) $display("FAIL mm_done: got ok=%0d found=%0d", ok, found);
    else begin
      e = sb.pop_front();
      if (out_sum !== e.sum || out_mismatch !== e.mm || out_sum !== SW'(361) || out_mismatch !== 1'b1)
        $display("FAIL mm_result: got %0d/%b want %0d/%b", out_sum, out_mismatch, e.sum, e.mm);
      else n_pass++;
    end
    @(negedge clk);
    bias = '0;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] ops [L];
    bit ok, found;
    int last, at, seen;
    exp_t e;
    for (int i = 0; i < L; i++) ops[i] = W'(i + 1);
    out_ready = 1'b1;
    feed(ops, 0, ok, last);
    rst = 1'b1;
    #1;
    n_total++;
    if (tree_operands !== '0 || out_valid !== 1'b0)
      $display("FAIL rstmid_clear: got ops=%0h v=%b want 0/0", tree_operands, out_valid);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1 || tree_operands !== '0)
      $display("FAIL rstmid_release: got in_ready=%b ops=%0h want 1/0", in_ready, tree_operands);
    else n_pass++;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_total++;
    if (seen != 0) $display("FAIL rstmid_noresult: got %0d valid cycles want 0", seen);
    else n_pass++;
    for (int i = 0; i < L; i++) ops[i] = W'(2);
    feed(ops, 0, ok, last);
    wait_valid(found, at);
    n_total++;
    if (!ok || !found || sb.size() == 0) $display("FAIL rstmid_second: got ok=%0d found=%0d", ok, found);
    else begin
      e = sb.pop_front();
      if (out_sum !== e.sum || out_sum !== SW'(16) || out_mismatch !== 1'b0)
        $display("FAIL rstmid_second: got %0d/%b want %0d/0", out_sum, out_mismatch, e.sum);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_gaps();
    logic [W-1:0] ops [L];
    bit ok, found;
    int last, at;
    exp_t e;
    for (int i = 0; i < L; i++) ops[i] = W'(100 + i);
    out_ready = 1'b1;
    feed(ops, 1, ok, last);
    wait_valid(found, at);
    n_total++;
    if (!ok || !found || (at - last) != TL + 1)
      $display("FAIL gaps_latency: got ok=%0d found=%0d latency=%0d want %0d", ok, found, at - last, TL + 1);
    else n_pass++;
    n_total++;
    if (sb.size() == 0) $display("FAIL gaps_sum: scoreboard empty got %0d", out_sum);
    else begin
      e = sb.pop_front();
      if (out_sum !== e.sum || out_sum !== SW'(828) || out_mismatch !== 1'b0)
        $display("FAIL gaps_sum: got %0d/%b want %0d/0", out_sum, out_mismatch, e.sum);
      else n_pass++;
    end
    @(negedge clk);
    for (int k = 0; k < L; k++) begin
      n_total++;
      if (tree_operands[k*W +: W] !== ops[k])
        $display("FAIL gaps_lane%0d: got %0d want %0d", k, tree_operands[k*W +: W], ops[k]);
      else n_pass++;
    end
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    bias      = '0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_mismatch();
    test_reset_mid();
    test_gaps();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
